// File: rtl/shared_pkg.sv
// Shared types and defaults for the ALSU datapath blocks.
package shared_pkg;

  typedef enum logic [2:0] {
    OR        = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    INVALID_6 = 3'd6,
    INVALID_7 = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } alsu_state_e;

  // "A" or "B": operand that wins when both bypass or both reduction bits are set.
  localparam INPUT_PRIORITY_DEFAULT = "A";
  // "ON" adds cin into ADD results, "OFF" ignores it.
  localparam FULL_ADDER_DEFAULT     = "ON";

endpackage

// File: rtl/alsu_seq_mult.sv
// Unsigned shift-add multiplier: loads on start, then runs WIDTH iterations.
// done is raised during the final iteration and product then carries the
// completed result, so the caller can register it on that same edge.
module alsu_seq_mult #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Load operands on start, otherwise add-and-shift once per cycle while counting down.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy    = (cnt_q != '0);
  assign done    = (cnt_q == CNT_W'(1));
  assign product = acc_d;

endmodule

// File: rtl/alsu_pipe.sv
// Handshaked ALSU: captures a command, executes it in one cycle (or WIDTH
// cycles for a multiply) and holds the result until the sink takes it.
module alsu_pipe
  import shared_pkg::*;
#(
  parameter int WIDTH          = 3,
  parameter     INPUT_PRIORITY = INPUT_PRIORITY_DEFAULT,
  parameter     FULL_ADDER     = FULL_ADDER_DEFAULT,
  parameter int LED_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic                   cin,
  input  logic                   serial_in,
  input  logic                   red_op_A,
  input  logic                   red_op_B,
  input  logic [2:0]             opcode,
  input  logic                   bypass_A,
  input  logic                   bypass_B,
  input  logic                   direction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out,
  output logic                   err,
  output logic [LED_WIDTH-1:0]   leds
);

  localparam int OUT_W  = 2 * WIDTH;
  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  alsu_state_e state_q, state_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic                 err_q, err_d;
  logic [LED_WIDTH-1:0] leds_q, leds_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  opcode_e          opcode_q, opcode_d;
  logic             cin_q, cin_d, serial_q, serial_d, dir_q, dir_d;
  logic             red_a_q, red_a_d, red_b_q, red_b_d;
  logic             byp_a_q, byp_a_d, byp_b_q, byp_b_d;

  logic             accept, mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [OUT_W-1:0] mul_product, mul_result;
  logic [OUT_W-1:0] a_ext, b_ext, res;
  logic             res_err, invalid, red_val;
  logic [WIDTH-1:0] red_src;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == 3'(MULT)) && !red_op_A && !red_op_B
                     && !bypass_A && !bypass_B;

  // The multiplier core works on magnitudes; the most-negative value maps to 2^(WIDTH-1).
  assign a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;

  alsu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a_mag),
    .b       (b_mag),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_result = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (~mul_product + 1'b1) : mul_product;

  // Capture the whole command on an accepted handshake, otherwise hold it.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    opcode_d = opcode_q;
    cin_d    = cin_q;
    serial_d = serial_q;
    dir_d    = dir_q;
    red_a_d  = red_a_q;
    red_b_d  = red_b_q;
    byp_a_d  = byp_a_q;
    byp_b_d  = byp_b_q;
    if (accept) begin
      a_d      = A;
      b_d      = B;
      opcode_d = opcode_e'(opcode);
      cin_d    = cin;
      serial_d = serial_in;
      dir_d    = direction;
      red_a_d  = red_op_A;
      red_b_d  = red_op_B;
      byp_a_d  = bypass_A;
      byp_b_d  = bypass_B;
    end
  end

  // Single-cycle result for everything except a real multiply; bypass beats invalid.
  always_comb begin
    res     = '0;
    res_err = 1'b0;
    a_ext   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    invalid = (opcode_q == INVALID_6) || (opcode_q == INVALID_7) ||
              ((red_a_q || red_b_q) && (opcode_q != OR) && (opcode_q != XOR));
    if (red_a_q && red_b_q) begin
      red_src = PRIO_A ? a_q : b_q;
    end else if (red_a_q) begin
      red_src = a_q;
    end else begin
      red_src = b_q;
    end
    red_val = (opcode_q == OR) ? |red_src : ^red_src;
    if (byp_a_q && byp_b_q) begin
      res = PRIO_A ? a_ext : b_ext;
    end else if (byp_a_q) begin
      res = a_ext;
    end else if (byp_b_q) begin
      res = b_ext;
    end else if (invalid) begin
      res     = '0;
      res_err = 1'b1;
    end else begin
      case (opcode_q)
        OR:      res = (red_a_q || red_b_q) ? {{(OUT_W-1){1'b0}}, red_val}
                                            : {{WIDTH{1'b0}}, a_q | b_q};
        XOR:     res = (red_a_q || red_b_q) ? {{(OUT_W-1){1'b0}}, red_val}
                                            : {{WIDTH{1'b0}}, a_q ^ b_q};
        ADD:     res = a_ext + b_ext + OUT_W'(cin_q & USE_CIN);
        SHIFT:   res = dir_q ? {out_q[OUT_W-2:0], serial_q} : {serial_q, out_q[OUT_W-1:1]};
        ROTATE:  res = dir_q ? {out_q[OUT_W-2:0], out_q[OUT_W-1]} : {out_q[0], out_q[OUT_W-1:1]};
        default: res = '0;
      endcase
    end
  end

  // Next state plus result/err/leds updates, which only happen at the result write.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = err_q;
    leds_d  = leds_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = mul_start ? MUL : EXEC;
        end
      end
      EXEC: begin
        out_d   = res;
        err_d   = res_err;
        leds_d  = res_err ? ~leds_q : '0;
        state_d = DONE;
      end
      MUL: begin
        if (mul_done) begin
          out_d   = mul_result;
          err_d   = 1'b0;
          leds_d  = '0;
          state_d = DONE;
        end else if (!mul_busy) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, result and captured-command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      err_q    <= 1'b0;
      leds_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opcode_q <= OR;
      cin_q    <= 1'b0;
      serial_q <= 1'b0;
      dir_q    <= 1'b0;
      red_a_q  <= 1'b0;
      red_b_q  <= 1'b0;
      byp_a_q  <= 1'b0;
      byp_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      err_q    <= err_d;
      leds_q   <= leds_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opcode_q <= opcode_d;
      cin_q    <= cin_d;
      serial_q <= serial_d;
      dir_q    <= dir_d;
      red_a_q  <= red_a_d;
      red_b_q  <= red_b_d;
      byp_a_q  <= byp_a_d;
      byp_b_q  <= byp_b_d;
    end
  end

  assign out  = out_q;
  assign err  = err_q;
  assign leds = leds_q;

endmodule

// File: tb/tb_alsu_pipe.sv
// Directed bench for alsu_pipe at WIDTH=3, INPUT_PRIORITY="A", FULL_ADDER="ON".
module tb_alsu_pipe;

  localparam int WIDTH     = 3;
  localparam int OUT_W     = 6;
  localparam int LED_WIDTH = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid, in_ready;
  logic signed [WIDTH-1:0] A, B;
  logic                  cin, serial_in, red_op_A, red_op_B;
  logic [2:0]            opcode;
  logic                  bypass_A, bypass_B, direction;
  logic                  out_valid, out_ready;
  logic [OUT_W-1:0]      out;
  logic                  err;
  logic [LED_WIDTH-1:0]  leds;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alsu_pipe #(
    .WIDTH          (WIDTH),
    .INPUT_PRIORITY ("A"),
    .FULL_ADDER     ("ON"),
    .LED_WIDTH      (LED_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .serial_in (serial_in),
    .red_op_A  (red_op_A),
    .red_op_B  (red_op_B),
    .opcode    (opcode),
    .bypass_A  (bypass_A),
    .bypass_B  (bypass_B),
    .direction (direction),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .err       (err),
    .leds      (leds)
  );

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for in_ready, present one command for a single accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                               input logic c, input logic ser, input logic ra, input logic rb,
                               input logic ba, input logic bb, input logic dir);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    opcode    = op;
    A         = a;
    B         = b;
    cin       = c;
    serial_in = ser;
    red_op_A  = ra;
    red_op_B  = rb;
    bypass_A  = ba;
    bypass_B  = bb;
    direction = dir;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  // Count edges from accept until out_valid, bounded so a stuck DUT still ends.
  task automatic waitValid(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("out_valid_arrives", {31'b0, out_valid}, 32'd1);
  endtask

  // Issue one command with out_ready high, check latency, result, err, leds, then drain.
  task automatic runCmd(input string tag, input logic [2:0] op, input logic [2:0] a,
                        input logic [2:0] b, input logic c, input logic ser,
                        input logic ra, input logic rb, input logic ba, input logic bb,
                        input logic dir, input int expLat, input logic [OUT_W-1:0] expOut,
                        input logic expErr, input logic [LED_WIDTH-1:0] expLeds);
    int edges;
    applyStimulus(op, a, b, c, ser, ra, rb, ba, bb, dir);
    checkOutput({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
    waitValid(edges);
    checkOutput({tag, "_latency"}, edges, expLat);
    checkOutput({tag, "_out"}, {26'b0, out}, {26'b0, expOut});
    checkOutput({tag, "_err"}, {31'b0, err}, {31'b0, expErr});
    checkOutput({tag, "_leds"}, {16'b0, leds}, {16'b0, expLeds});
    @(posedge clk); #1;
    checkOutput({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int edges;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; cin = 1'b0; serial_in = 1'b0; red_op_A = 1'b0; red_op_B = 1'b0;
    opcode = 3'd0; bypass_A = 1'b0; bypass_B = 1'b0; direction = 1'b0;
    #12;
    checkOutput("reset_out", {26'b0, out}, 32'd0);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset_err", {31'b0, err}, 32'd0);
    checkOutput("reset_leds", {16'b0, leds}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Multiply: -4 * -4 = 16, -4 * 3 = -12, three edges each.
    runCmd("mul_m4_m4", 3'd3, 3'b100, 3'b100, 0, 0, 0, 0, 0, 0, 0, 3, 6'b010000, 0, 16'h0000);
    runCmd("mul_m4_p3", 3'd3, 3'b100, 3'b011, 0, 0, 0, 0, 0, 0, 0, 3, 6'b110100, 0, 16'h0000);
    // Add with carry-in, and a negative sum.
    runCmd("add_3_3_c", 3'd2, 3'b011, 3'b011, 1, 0, 0, 0, 0, 0, 0, 1, 6'b000111, 0, 16'h0000);
    runCmd("add_m4_m1", 3'd2, 3'b100, 3'b111, 0, 0, 0, 0, 0, 0, 0, 1, 6'b111011, 0, 16'h0000);
    // Invalid opcodes toggle the LEDs; a valid result clears them.
    runCmd("inv6_first",  3'd6, 3'b001, 3'b001, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 1, 16'hFFFF);
    runCmd("inv6_second", 3'd6, 3'b001, 3'b001, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 1, 16'h0000);
    runCmd("inv7_third",  3'd7, 3'b001, 3'b001, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 1, 16'hFFFF);
    runCmd("or_clears",   3'd0, 3'b101, 3'b010, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000111, 0, 16'h0000);
    // Shift and rotate operate on the previous result.
    runCmd("or_seed",     3'd0, 3'b101, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000101, 0, 16'h0000);
    runCmd("shl_ser1",    3'd4, 3'b000, 3'b000, 0, 1, 0, 0, 0, 0, 1, 1, 6'b001011, 0, 16'h0000);
    runCmd("rotr",        3'd5, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100101, 0, 16'h0000);
    runCmd("rotl",        3'd5, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 6'b001011, 0, 16'h0000);
    runCmd("shr_ser1",    3'd4, 3'b000, 3'b000, 0, 1, 0, 0, 0, 0, 0, 1, 6'b100101, 0, 16'h0000);
    // Reductions, priority on both bits, reduction with a non-logic op is invalid.
    runCmd("xor_red_a",   3'd1, 3'b111, 3'b000, 0, 0, 1, 0, 0, 0, 0, 1, 6'b000001, 0, 16'h0000);
    runCmd("or_red_both", 3'd0, 3'b000, 3'b111, 0, 0, 1, 1, 0, 0, 0, 1, 6'b000000, 0, 16'h0000);
    runCmd("add_red_inv", 3'd2, 3'b001, 3'b001, 0, 0, 0, 1, 0, 0, 0, 1, 6'b000000, 1, 16'hFFFF);
    // Bypass overrides invalid and skips the multiplier.
    runCmd("byp_b_inv7",  3'd7, 3'b000, 3'b001, 0, 0, 0, 0, 0, 1, 0, 1, 6'b000001, 0, 16'h0000);
    runCmd("byp_a_mult",  3'd3, 3'b101, 3'b011, 0, 0, 0, 0, 1, 0, 0, 1, 6'b111101, 0, 16'h0000);

    // Back-pressure: result held for five cycles while a new command waits.
    out_ready = 1'b0;
    applyStimulus(3'd2, 3'b001, 3'b001, 0, 0, 0, 0, 0, 0, 0);
    waitValid(edges);
    checkOutput("bp_out", {26'b0, out}, {26'b0, 6'b000010});
    opcode = 3'd0; A = 3'b111; B = 3'b111; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold_out", {26'b0, out}, {26'b0, 6'b000010});
      checkOutput("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_drain_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_drain_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("bp_drain_out_kept", {26'b0, out}, {26'b0, 6'b000010});
    runCmd("bp_next_cmd", 3'd2, 3'b010, 3'b001, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000011, 0, 16'h0000);

    // Leave err/leds set, then reset in the middle of a multiply.
    runCmd("pre_rst_inv", 3'd6, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 1, 16'hFFFF);
    applyStimulus(3'd3, 3'b011, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midmul_rst_out", {26'b0, out}, 32'd0);
    checkOutput("midmul_rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midmul_rst_err", {31'b0, err}, 32'd0);
    checkOutput("midmul_rst_leds", {16'b0, leds}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("post_rst_idle", {31'b0, in_ready}, 32'd1);
      checkOutput("post_rst_no_out", {31'b0, out_valid}, 32'd0);
    end
    checkOutput("post_rst_out", {26'b0, out}, 32'd0);
    runCmd("byp_both_prio_a", 3'd2, 3'b110, 3'b001, 0, 0, 0, 0, 1, 1, 0, 1, 6'b111110, 0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
